// File: rtl/risXv_pkg.sv
// Shared types and widths for the risXv memory-side blocks.
package risXv_pkg;

    localparam int MXLEN   = 32;
    localparam int DATA_WD = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of LSU grants taken while fetch was waiting; forces a fetch
// grant once the limit is reached.
module mem_arb_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ls_grant,
    input  logic if_grant,
    input  logic if_waiting,
    output logic force_if
);

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("mem_arb_starve_ctr: STARVE_MAX must be in 1..15");
    end

    localparam logic [3:0] LIMIT = 4'(STARVE_MAX);

    logic [3:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 4'd0;
        end else if (if_grant) begin
            count <= 4'd0;
        end else if (ls_grant && if_waiting && count != LIMIT) begin
            count <= count + 4'd1;
        end
    end

    assign force_if = (count == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Two-client (fetch / LSU) arbiter onto a single memory port with one
// outstanding transaction and starvation protection for fetch.
module mem_arbiter
    import risXv_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               if_req_valid,
    input  logic [MXLEN-1:0]   if_req_addr,
    output logic               if_req_ready,
    output logic               if_rsp_valid,
    output logic [DATA_WD-1:0] if_rsp_data,

    input  logic               ls_req_valid,
    input  logic [MXLEN-1:0]   ls_req_addr,
    input  logic               ls_req_we,
    input  logic [DATA_WD-1:0] ls_req_wdata,
    input  logic [3:0]         ls_req_be,
    output logic               ls_req_ready,
    output logic               ls_rsp_valid,
    output logic [DATA_WD-1:0] ls_rsp_data,

    output logic               mem_req_valid,
    output logic [MXLEN-1:0]   mem_req_addr,
    output logic               mem_req_we,
    output logic [DATA_WD-1:0] mem_req_wdata,
    output logic [3:0]         mem_req_be,
    input  logic               mem_req_ready,
    input  logic               mem_rsp_valid,
    input  logic [DATA_WD-1:0] mem_rsp_data
);

    arb_state_e state;
    arb_owner_e owner;
    logic       force_if;
    logic       idle;
    logic       grant_if;
    logic       grant_ls;

    // Qualifying with rst keeps both readies low while reset is held.
    assign idle     = (state == ST_IDLE) && rst;
    assign grant_ls = idle && ls_req_valid && !(if_req_valid && force_if);
    assign grant_if = idle && if_req_valid && !grant_ls;

    assign if_req_ready = grant_if;
    assign ls_req_ready = grant_ls;

    mem_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk        (clk),
        .rst        (rst),
        .ls_grant   (grant_ls),
        .if_grant   (grant_if),
        .if_waiting (if_req_valid),
        .force_if   (force_if)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            owner         <= OWN_IF;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_we    <= 1'b0;
            mem_req_wdata <= '0;
            mem_req_be    <= 4'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_if) begin
                        owner         <= OWN_IF;
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= if_req_addr;
                        mem_req_we    <= 1'b0;
                        mem_req_wdata <= '0;
                        mem_req_be    <= 4'hF;
                        state         <= ST_ISSUE;
                    end else if (grant_ls) begin
                        owner         <= OWN_LS;
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= ls_req_addr;
                        mem_req_we    <= ls_req_we;
                        mem_req_wdata <= ls_req_wdata;
                        mem_req_be    <= ls_req_be;
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_rsp_valid) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Responses outside WAIT are stray and never reach a client.
    assign if_rsp_valid = (state == ST_WAIT) && mem_rsp_valid && (owner == OWN_IF);
    assign ls_rsp_valid = (state == ST_WAIT) && mem_rsp_valid && (owner == OWN_LS);
    assign if_rsp_data  = mem_rsp_data;
    assign ls_rsp_data  = mem_rsp_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table of single transactions plus
// hand-written sequences for starvation, stalls, stray responses and reset.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_valid = 1'b0;
    logic [31:0] if_req_addr = '0;
    logic        if_req_ready;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        ls_req_valid = 1'b0;
    logic [31:0] ls_req_addr = '0;
    logic        ls_req_we = 1'b0;
    logic [31:0] ls_req_wdata = '0;
    logic [3:0]  ls_req_be = '0;
    logic        ls_req_ready;
    logic        ls_rsp_valid;
    logic [31:0] ls_rsp_data;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_we;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_be;
    logic        mem_req_ready = 1'b0;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req_valid  (if_req_valid),
        .if_req_addr   (if_req_addr),
        .if_req_ready  (if_req_ready),
        .if_rsp_valid  (if_rsp_valid),
        .if_rsp_data   (if_rsp_data),
        .ls_req_valid  (ls_req_valid),
        .ls_req_addr   (ls_req_addr),
        .ls_req_we     (ls_req_we),
        .ls_req_wdata  (ls_req_wdata),
        .ls_req_be     (ls_req_be),
        .ls_req_ready  (ls_req_ready),
        .ls_rsp_valid  (ls_rsp_valid),
        .ls_rsp_data   (ls_rsp_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_we    (mem_req_we),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_be    (mem_req_be),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data)
    );

    typedef struct {
        logic        if_v;
        logic [31:0] if_addr;
        logic        ls_v;
        logic [31:0] ls_addr;
        logic        ls_we;
        logic [31:0] ls_wdata;
        logic [3:0]  ls_be;
        logic [31:0] rdata;
        logic        exp_ls;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
    } vec_t;

    vec_t vecs[6];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check_output({tag, "_if_ready"},  if_req_ready,  1'b0);
        check_output({tag, "_ls_ready"},  ls_req_ready,  1'b0);
        check_output({tag, "_if_rsp"},    if_rsp_valid,  1'b0);
        check_output({tag, "_ls_rsp"},    ls_rsp_valid,  1'b0);
        check_output({tag, "_mem_valid"}, mem_req_valid, 1'b0);
        check_output({tag, "_mem_addr"},  mem_req_addr,  32'h0);
        check_output({tag, "_mem_we"},    mem_req_we,    1'b0);
        check_output({tag, "_mem_wdata"}, mem_req_wdata, 32'h0);
        check_output({tag, "_mem_be"},    mem_req_be,    4'h0);
    endtask

    // Called at posedge+1; holds reset with both clients requesting.
    task automatic do_reset();
        rst = 1'b0;
        if_req_valid = 1'b1;
        ls_req_valid = 1'b1;
        @(negedge clk);
        check_quiet("reset");
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic apply_stimulus(input vec_t v);
        if_req_valid  = v.if_v;
        if_req_addr   = v.if_addr;
        ls_req_valid  = v.ls_v;
        ls_req_addr   = v.ls_addr;
        ls_req_we     = v.ls_we;
        ls_req_wdata  = v.ls_wdata;
        ls_req_be     = v.ls_be;
        mem_req_ready = 1'b0;
        @(negedge clk);
        check_output("grant_if", if_req_ready, !v.exp_ls);
        check_output("grant_ls", ls_req_ready, v.exp_ls);
        @(posedge clk); #1;
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        @(negedge clk);
        check_output("issue_valid", mem_req_valid, 1'b1);
        check_output("issue_addr",  mem_req_addr,  v.exp_addr);
        check_output("issue_we",    mem_req_we,    v.exp_we);
        check_output("issue_wdata", mem_req_wdata, v.exp_wdata);
        check_output("issue_be",    mem_req_be,    v.exp_be);
        check_output("issue_ready", {if_req_ready, ls_req_ready}, 2'b00);
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = v.rdata;
        @(negedge clk);
        check_output("wait_mem_valid", mem_req_valid, 1'b0);
        check_output("rsp_if_valid",   if_rsp_valid, !v.exp_ls);
        check_output("rsp_ls_valid",   ls_rsp_valid, v.exp_ls);
        check_output("rsp_data",       v.exp_ls ? ls_rsp_data : if_rsp_data, v.rdata);
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        check_output("pulse_end", {if_rsp_valid, ls_rsp_valid}, 2'b00);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [9:0] exp_seq;
        vec_t       v;

        vecs[0] = '{1'b1, 32'h100, 1'b0, 32'h0,  1'b0, 32'hFFFF_FFFF, 4'h5, 32'hDEAD_BEEF,
                    1'b0, 32'h100, 1'b0, 32'h0, 4'hF};
        vecs[1] = '{1'b0, 32'h0,   1'b1, 32'h40, 1'b0, 32'h0,         4'hF, 32'hCAFE_F00D,
                    1'b1, 32'h40,  1'b0, 32'h0, 4'hF};
        vecs[2] = '{1'b0, 32'h0,   1'b1, 32'h20, 1'b1, 32'h1234_5678, 4'h3, 32'h0,
                    1'b1, 32'h20,  1'b1, 32'h1234_5678, 4'h3};
        vecs[3] = '{1'b1, 32'h200, 1'b1, 32'h80, 1'b1, 32'hA5A5_0001, 4'hC, 32'h1111_2222,
                    1'b1, 32'h80,  1'b1, 32'hA5A5_0001, 4'hC};
        vecs[4] = '{1'b1, 32'h204, 1'b0, 32'h0,  1'b0, 32'h0,         4'h0, 32'h3333_4444,
                    1'b0, 32'h204, 1'b0, 32'h0, 4'hF};
        vecs[5] = '{1'b1, 32'h208, 1'b1, 32'h84, 1'b0, 32'h0,         4'h1, 32'h5555_6666,
                    1'b1, 32'h84,  1'b0, 32'h0, 4'h1};

        @(posedge clk); #1;
        do_reset();

        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vecs[i]);
        end

        // Starvation: both clients request continuously; fetch forced every 5th grant.
        do_reset();
        exp_seq = 10'b01_1110_1111;
        if_req_valid = 1'b1;
        if_req_addr  = 32'h300;
        ls_req_valid = 1'b1;
        ls_req_addr  = 32'h400;
        ls_req_we    = 1'b0;
        ls_req_be    = 4'hF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_output("order_ls", ls_req_ready, exp_seq[i]);
            check_output("order_if", if_req_ready, !exp_seq[i]);
            @(posedge clk); #1;
            mem_req_ready = 1'b1;
            @(negedge clk);
            check_output("order_addr", mem_req_addr, exp_seq[i] ? 32'h400 : 32'h300);
            @(posedge clk); #1;
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b1;
            @(posedge clk); #1;
            mem_rsp_valid = 1'b0;
        end
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        @(posedge clk); #1;

        // Write stalled by the memory for three cycles; request must hold.
        ls_req_valid = 1'b1;
        ls_req_addr  = 32'h20;
        ls_req_we    = 1'b1;
        ls_req_wdata = 32'h1234_5678;
        ls_req_be    = 4'b0011;
        @(posedge clk); #1;
        ls_req_valid = 1'b0;
        ls_req_addr  = 32'hFFFF;
        ls_req_wdata = 32'h0;
        ls_req_be    = 4'hF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_output("stall_valid", mem_req_valid, 1'b1);
            check_output("stall_addr",  mem_req_addr,  32'h20);
            check_output("stall_we",    mem_req_we,    1'b1);
            check_output("stall_wdata", mem_req_wdata, 32'h1234_5678);
            check_output("stall_be",    mem_req_be,    4'b0011);
            mem_req_ready = (k == 3);
            @(posedge clk); #1;
        end
        mem_req_ready = 1'b0;
        @(negedge clk);
        check_output("stall_no_early_ack", ls_rsp_valid, 1'b0);
        mem_rsp_valid = 1'b1;
        #1;
        check_output("stall_ack", ls_rsp_valid, 1'b1);
        check_output("stall_ack_if", if_rsp_valid, 1'b0);
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        check_output("stall_ack_end", ls_rsp_valid, 1'b0);
        @(posedge clk); #1;

        // Stray responses in IDLE and ISSUE.
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0BAD_0BAD;
        @(negedge clk);
        check_output("stray_idle_rsp", {if_rsp_valid, ls_rsp_valid}, 2'b00);
        check_output("stray_idle_mem", mem_req_valid, 1'b0);
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        if_req_valid  = 1'b1;
        if_req_addr   = 32'h500;
        @(posedge clk); #1;
        if_req_valid  = 1'b0;
        mem_rsp_valid = 1'b1;
        @(negedge clk);
        check_output("stray_issue_rsp", {if_rsp_valid, ls_rsp_valid}, 2'b00);
        check_output("stray_issue_mem", mem_req_valid, 1'b1);
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        check_output("stray_still_issue", mem_req_valid, 1'b1);
        check_output("stray_addr", mem_req_addr, 32'h500);
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0000_55AA;
        @(negedge clk);
        check_output("stray_real_rsp", if_rsp_valid, 1'b1);
        check_output("stray_real_data", if_rsp_data, 32'h0000_55AA);
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        @(posedge clk); #1;

        // Reset while waiting; the late response must be dropped.
        if_req_valid = 1'b1;
        if_req_addr  = 32'h600;
        @(posedge clk); #1;
        if_req_valid  = 1'b0;
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check_quiet("wait_reset");
        @(posedge clk); #1;
        rst = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h7777_7777;
        @(negedge clk);
        check_output("late_rsp", {if_rsp_valid, ls_rsp_valid}, 2'b00);
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        v = '{1'b1, 32'h604, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h8888_9999,
              1'b0, 32'h604, 1'b0, 32'h0, 4'hF};
        apply_stimulus(v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
